// File: rtl/ahfp_add_multi.sv
// ahfp_add_multi: 7-stage pipelined IEEE-754 single-precision adder (dataa + datab)
// behind the Nios II multi-cycle custom-instruction handshake.
//   clk     : clock, all state on rising edge
//   reset   : asynchronous active-high; clears stage valids, done and result
//   clk_en  : pipeline advance enable; low freezes every register
//   start   : operands valid this cycle (qualified by clk_en)
//   dataa   : operand A, IEEE-754 single
//   datab   : operand B, IEEE-754 single
//   done    : one-cycle result-valid pulse per accepted start
//   result  : A+B, round-to-nearest-even, denormals flushed to zero
// Also contains ahfp_lzd48, the shared 48-bit leading-zero detector.

// Leading-zero count of a 48-bit vector; zero flags an all-zero input.
module ahfp_lzd48 (
   input  logic [47:0] value,
   output logic [5:0]  count,
   output logic        zero
);

   // Ascending scan: the last hit is the highest set bit.
   always_comb begin
      count = 6'd0;
      for (int i = 0; i < 48; i++) begin
         if (value[i]) count = 6'(47 - i);
      end
   end

   assign zero = ~|value;

endmodule

module ahfp_add_multi #(
   parameter int unsigned LATENCY     = 7,
   parameter int unsigned ALIGN_LIMIT = 26
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_en,
   input  logic        start,
   input  logic [31:0] dataa,
   input  logic [31:0] datab,
   output logic        done,
   output logic [31:0] result
);

   localparam int unsigned EXP_W  = 8;
   localparam int unsigned MAN_W  = 24;
   localparam int unsigned EXT_W  = 27;
   localparam int unsigned SUM_W  = 28;
   localparam int unsigned SEXP_W = 10;
   localparam logic [31:0] QNAN   = 32'h7FC0_0000;

   // Control that rides alongside the datapath from stage 2 onwards.
   typedef struct packed {
      logic        sign;
      logic        sub;
      logic        spec;
      logic [31:0] spec_val;
   } ctrl_t;

   // Stage valid shift chain; the last bit is the done flop.
   logic [LATENCY-1:0] vld;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       vld <= '0;
      else if (clk_en) vld <= {vld[LATENCY-2:0], start};
   end

   assign done = vld[LATENCY-1];

   // ---------------- Stage 1: unpack ----------------
   logic             s1_sa, s1_sb;
   logic [EXP_W-1:0] s1_ea, s1_eb;
   logic [MAN_W-1:0] s1_ma, s1_mb;
   logic             s1_nan_a, s1_nan_b, s1_inf_a, s1_inf_b;

   // Exponent 0 flushes to zero, so the implicit one doubles as the mantissa mask.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_sa    <= 1'b0;
         s1_sb    <= 1'b0;
         s1_ea    <= '0;
         s1_eb    <= '0;
         s1_ma    <= '0;
         s1_mb    <= '0;
         s1_nan_a <= 1'b0;
         s1_nan_b <= 1'b0;
         s1_inf_a <= 1'b0;
         s1_inf_b <= 1'b0;
      end else if (clk_en) begin
         s1_sa    <= dataa[31];
         s1_sb    <= datab[31];
         s1_ea    <= dataa[30:23];
         s1_eb    <= datab[30:23];
         s1_ma    <= {1'b1, dataa[22:0]} & {MAN_W{|dataa[30:23]}};
         s1_mb    <= {1'b1, datab[22:0]} & {MAN_W{|datab[30:23]}};
         s1_nan_a <= (&dataa[30:23]) & (|dataa[22:0]);
         s1_nan_b <= (&datab[30:23]) & (|datab[22:0]);
         s1_inf_a <= (&dataa[30:23]) & ~(|dataa[22:0]);
         s1_inf_b <= (&datab[30:23]) & ~(|datab[22:0]);
      end
   end

   // ---------------- Stage 2: order by magnitude, resolve specials ----------------
   logic             n2_a_ge, n2_nan, n2_inf;
   ctrl_t            n2_ctrl, s2_ctrl;
   logic [EXP_W-1:0] s2_el, s2_es;
   logic [MAN_W-1:0] s2_ml, s2_ms;

   always_comb begin
      n2_a_ge          = {s1_ea, s1_ma} >= {s1_eb, s1_mb};
      n2_nan           = s1_nan_a | s1_nan_b | (s1_inf_a & s1_inf_b & (s1_sa ^ s1_sb));
      n2_inf           = s1_inf_a | s1_inf_b;
      n2_ctrl.sign     = n2_a_ge ? s1_sa : s1_sb;
      n2_ctrl.sub      = s1_sa ^ s1_sb;
      n2_ctrl.spec     = n2_nan | n2_inf;
      n2_ctrl.spec_val = n2_nan ? QNAN : {(s1_inf_a ? s1_sa : s1_sb), 8'hFF, 23'd0};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_ctrl <= '0;
         s2_el   <= '0;
         s2_es   <= '0;
         s2_ml   <= '0;
         s2_ms   <= '0;
      end else if (clk_en) begin
         s2_ctrl <= n2_ctrl;
         s2_el   <= n2_a_ge ? s1_ea : s1_eb;
         s2_es   <= n2_a_ge ? s1_eb : s1_ea;
         s2_ml   <= n2_a_ge ? s1_ma : s1_mb;
         s2_ms   <= n2_a_ge ? s1_mb : s1_ma;
      end
   end

   // ---------------- Stage 3: align smaller operand ----------------
   logic [EXP_W-1:0]     n3_d;
   logic [2*EXT_W-1:0]   n3_wide;
   logic [EXT_W-1:0]     n3_ms;
   ctrl_t                s3_ctrl;
   logic [EXP_W-1:0]     s3_exp;
   logic [EXT_W-1:0]     s3_ml, s3_ms;

   // Lower half of the wide shift holds everything pushed past the sticky bit.
   always_comb begin
      n3_d    = s2_el - s2_es;
      n3_wide = {s2_ms, 3'b000, 27'd0} >> n3_d;
      if (32'(n3_d) > ALIGN_LIMIT) n3_ms = {26'd0, |s2_ms};
      else                         n3_ms = n3_wide[53:27] | {26'd0, |n3_wide[26:0]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s3_ctrl <= '0;
         s3_exp  <= '0;
         s3_ml   <= '0;
         s3_ms   <= '0;
      end else if (clk_en) begin
         s3_ctrl <= s2_ctrl;
         s3_exp  <= s2_el;
         s3_ml   <= {s2_ml, 3'b000};
         s3_ms   <= n3_ms;
      end
   end

   // ---------------- Stage 4: add / subtract ----------------
   logic [SUM_W-1:0]         n4_sum;
   logic [EXT_W-1:0]         n4_m;
   logic signed [SEXP_W-1:0] n4_exp;
   ctrl_t                    s4_ctrl;
   logic [EXT_W-1:0]         s4_m;
   logic signed [SEXP_W-1:0] s4_exp;

   // |large| >= |aligned small| so the subtract never goes negative.
   always_comb begin
      if (s3_ctrl.sub) n4_sum = {1'b0, s3_ml} - {1'b0, s3_ms};
      else             n4_sum = {1'b0, s3_ml} + {1'b0, s3_ms};
      if (n4_sum[27]) n4_m = {n4_sum[27:2], |n4_sum[1:0]};
      else            n4_m = n4_sum[26:0];
      n4_exp = 10'(s3_exp) + 10'(n4_sum[27]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s4_ctrl <= '0;
         s4_m    <= '0;
         s4_exp  <= '0;
      end else if (clk_en) begin
         s4_ctrl <= s3_ctrl;
         s4_m    <= n4_m;
         s4_exp  <= n4_exp;
      end
   end

   // ---------------- Stage 5: normalise ----------------
   logic [5:0]               n5_lz;
   logic                     n5_zero;
   ctrl_t                    s5_ctrl;
   logic [EXT_W-1:0]         s5_m;
   logic signed [SEXP_W-1:0] s5_exp;
   logic                     s5_zero;

   ahfp_lzd48 u_lzd (
      .value (({s4_m, 21'd0})),
      .count (n5_lz),
      .zero  (n5_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s5_ctrl <= '0;
         s5_m    <= '0;
         s5_exp  <= '0;
         s5_zero <= 1'b0;
      end else if (clk_en) begin
         s5_ctrl <= s4_ctrl;
         s5_m    <= s4_m << n5_lz;
         s5_exp  <= s4_exp - 10'(n5_lz);
         s5_zero <= n5_zero;
      end
   end

   // ---------------- Stage 6: round to nearest even ----------------
   logic                     n6_up;
   logic [MAN_W:0]           n6_m25;
   ctrl_t                    s6_ctrl;
   logic [22:0]              s6_frac;
   logic signed [SEXP_W-1:0] s6_exp;
   logic                     s6_zero;

   // Bits [2:0] are guard, round, sticky; a carry into bit 24 renormalises.
   always_comb begin
      n6_up  = s5_m[2] & (s5_m[1] | s5_m[0] | s5_m[3]);
      n6_m25 = {1'b0, s5_m[26:3]} + 25'(n6_up);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s6_ctrl <= '0;
         s6_frac <= '0;
         s6_exp  <= '0;
         s6_zero <= 1'b0;
      end else if (clk_en) begin
         s6_ctrl <= s5_ctrl;
         s6_frac <= n6_m25[24] ? n6_m25[23:1] : n6_m25[22:0];
         s6_exp  <= s5_exp + 10'(n6_m25[24]);
         s6_zero <= s5_zero;
      end
   end

   // ---------------- Stage 7: pack and range check ----------------
   logic [31:0] n7_res;

   // An exact zero keeps its sign only for a true add (-0 + -0); cancellation gives +0.
   always_comb begin
      if (s6_ctrl.spec)               n7_res = s6_ctrl.spec_val;
      else if (s6_zero)               n7_res = {s6_ctrl.sign & ~s6_ctrl.sub, 31'd0};
      else if (s6_exp >= 10'sd255)    n7_res = {s6_ctrl.sign, 8'hFF, 23'd0};
      else if (s6_exp <= 10'sd0)      n7_res = {s6_ctrl.sign, 31'd0};
      else                            n7_res = {s6_ctrl.sign, s6_exp[7:0], s6_frac};
   end

   // result holds its last value when no op reaches the output stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                             result <= 32'h0;
      else if (clk_en && vld[LATENCY-2])     result <= n7_res;
   end

endmodule

// File: tb/tb_ahfp_add_multi.sv
// Scoreboard bench for ahfp_add_multi: the driver pushes hand-computed results
// with their expected done cycle; a monitor pops on every fresh done.
module tb_ahfp_add_multi;

   logic        clk = 1'b0;
   logic        reset;
   logic        clk_en;
   logic        start;
   logic [31:0] dataa, datab;
   logic        done;
   logic [31:0] result;

   ahfp_add_multi dut (
      .clk    (clk),
      .reset  (reset),
      .clk_en (clk_en),
      .start  (start),
      .dataa  (dataa),
      .datab  (datab),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      int          cyc;
      int          id;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   bit   edge_en = 1'b0;
   int   compared = 0;
   int   mismatched = 0;
   int   next_id = 0;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      edge_en <= clk_en;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endtask

   // Monitor: one pop per done seen after an enabled edge (a stalled done is not new).
   always @(negedge clk) begin
      if (!reset && edge_en && done === 1'b1) begin
         if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("result#%0d", e.id), result, e.res);
            check($sformatf("latency#%0d", e.id), 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op this cycle; if push, expect done lat cycles later.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                        input int lat, input bit push);
      exp_t e;
      start = 1'b1;
      dataa = a;
      datab = b;
      if (push) begin
         e.res = r;
         e.cyc = cyc + lat;
         e.id  = next_id;
         sb.push_back(e);
      end
      next_id++;
      tick();
      start = 1'b0;
   endtask

   localparam int NV = 22;
   logic [31:0] va [NV] = '{
      32'h3F800000, 32'h80000000, 32'h3F800000, 32'h3F800000, 32'h7F7FFFFF, 32'h7F800000,
      32'h00000001, 32'h40400000, 32'h41200000, 32'h3F800000, 32'hFF800000, 32'h00000000,
      32'h00800000, 32'h00C00000, 32'h3F800000, 32'hC0000000, 32'h3F800000, 32'h4B800001,
      32'h7F000000, 32'h3F800000, 32'h3FFFFFFF, 32'h4B7FFFFF};
   logic [31:0] vb [NV] = '{
      32'hBF800000, 32'h80000000, 32'h33800000, 32'h34400000, 32'h7F7FFFFF, 32'hFF800000,
      32'h3F800000, 32'hC0000000, 32'hC1100000, 32'h7FC00000, 32'h3F800000, 32'h80000000,
      32'h00800000, 32'h80800000, 32'hBF7FFFFF, 32'h3F800000, 32'h4B800000, 32'h3F800000,
      32'h7F000000, 32'h00000000, 32'h3F800000, 32'h3F000000};
   logic [31:0] vr [NV] = '{
      32'h00000000, 32'h80000000, 32'h3F800000, 32'h3F800002, 32'h7F800000, 32'h7FC00000,
      32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 32'hFF800000, 32'h00000000,
      32'h01000000, 32'h00000000, 32'h33800000, 32'hBF800000, 32'h4B800000, 32'h4B800002,
      32'h7F800000, 32'h3F800000, 32'h40400000, 32'h4B800000};

   initial begin
      reset  = 1'b1;
      clk_en = 1'b1;
      start  = 1'b0;
      dataa  = '0;
      datab  = '0;
      repeat (2) tick();
      @(negedge clk);
      check("reset_done", 32'(done), 32'd0);
      check("reset_result", result, 32'h0);
      tick();
      reset = 1'b0;
      repeat (2) tick();

      // Single op, latency 7.
      issue(32'h3F800000, 32'h40000000, 32'h40400000, 7, 1'b1);
      repeat (10) tick();

      // Directed vectors back to back.
      for (int i = 0; i < NV; i++) issue(va[i], vb[i], vr[i], 7, 1'b1);
      repeat (10) tick();

      // Three starts, then a two-cycle stall.
      issue(32'h3F800000, 32'h40000000, 32'h40400000, 9, 1'b1);
      issue(32'h40000000, 32'h40000000, 32'h40800000, 9, 1'b1);
      issue(32'h40A00000, 32'h3F800000, 32'h40C00000, 9, 1'b1);
      clk_en = 1'b0;
      repeat (2) tick();
      clk_en = 1'b1;
      repeat (10) tick();

      // Done held across a stall, cleared by the next enabled edge.
      issue(32'h40400000, 32'h40400000, 32'h40C00000, 7, 1'b1);
      repeat (6) tick();
      clk_en = 1'b0;
      @(negedge clk);
      check("done_at_stall", 32'(done), 32'd1);
      tick();
      @(negedge clk);
      check("done_held", 32'(done), 32'd1);
      check("result_held", result, 32'h40C00000);
      tick();
      clk_en = 1'b1;
      tick();
      @(negedge clk);
      check("done_cleared", 32'(done), 32'd0);
      repeat (3) tick();

      // Reset mid-flight discards the op; a later start still completes.
      issue(32'h3F800000, 32'h40000000, 32'h40400000, 7, 1'b0);
      repeat (2) tick();
      reset = 1'b1;
      @(negedge clk);
      check("midreset_done", 32'(done), 32'd0);
      check("midreset_result", result, 32'h0);
      tick();
      reset = 1'b0;
      tick();
      issue(32'h40000000, 32'h40000000, 32'h40800000, 7, 1'b1);
      @(negedge clk);
      check("post_reset_result", result, 32'h0);

      for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
      repeat (3) tick();
      check("queue_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
